// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants and elaboration helpers for the counter
//               primitive family (mode encodings, width and modulus checks).
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Saturation mode encodings for the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Legal parameter envelope
    localparam int MIN_WIDTH   = 1;
    localparam int MAX_WIDTH   = 32;
    localparam int MIN_MODULUS = 2;

    // Number of bits needed to represent values 0..value-1
    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int              r;
        r = 0;
        if (value > 64'd1) begin
            v = value - 64'd1;
            while (v != 64'd0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    // A modulus is legal when it has at least two states and all of its
    // states (0..modulus-1) fit in the counter width
    function automatic bit modulus_ok(input int width, input longint unsigned modulus);
        return (modulus >= longint'(MIN_MODULUS)) && (clog2(modulus) <= width);
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_tc_detect.sv
`default_nettype none
// ============================================================================
// Module      : counter_tc_detect
// Description : Combinational terminal-count compare. High when the counter
//               is enabled and sits at the end value for its direction, so
//               it can directly drive the enable of a following stage.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_tc_detect #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    output logic             tc
);

    logic w_at_max;
    logic w_at_min;

    assign w_at_max = (count == MAX_VAL);
    assign w_at_min = (count == '0);
    assign tc       = en & ((up & w_at_max) | (~up & w_at_min));

endmodule : counter_tc_detect
`default_nettype wire

// File: rtl/sync_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_updown_counter
// Description : Fully synchronous modulo-N up/down counter with parallel
//               load (clamped to the range), count enable, wrap or saturate
//               end behaviour, combinational terminal count for cascading and
//               a registered one-cycle wrap/saturate event pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter int              SATURATE  = MODE_WRAP,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
        $error("sync_updown_counter: WIDTH must be in 1..32");
    end
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("sync_updown_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("sync_updown_counter: RESET_VAL must be below MODULUS");
    end
    if ((SATURATE != MODE_WRAP) && (SATURATE != MODE_SAT)) begin : g_bad_mode
        $error("sync_updown_counter: SATURATE must be MODE_WRAP or MODE_SAT");
    end

    // Highest legal count; MODULUS-1 always fits in WIDTH bits, so all
    // range comparisons stay at WIDTH bits with no overflow reliance
    localparam logic [WIDTH-1:0] c_max   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
    localparam bit               c_sat   = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic             w_tc;
    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_clamped;

    counter_tc_detect #(
        .WIDTH   (WIDTH),
        .MAX_VAL (c_max)
    ) u_tc_detect (
        .count (r_count),
        .en    (en),
        .up    (up),
        .tc    (w_tc)
    );

    assign w_at_max       = (r_count == c_max);
    assign w_at_min       = (r_count == '0);
    assign w_load_clamped = (load_val > c_max) ? c_max : load_val;

    // Next value for one enabled step; at an end the counter either wraps
    // to the opposite end or holds, never leaving 0..MODULUS-1
    always_comb begin
        w_step = r_count;
        if (up) begin
            if (!w_at_max) begin
                w_step = r_count + c_one;
            end else if (!c_sat) begin
                w_step = '0;
            end
        end else begin
            if (!w_at_min) begin
                w_step = r_count - c_one;
            end else if (!c_sat) begin
                w_step = c_max;
            end
        end
    end

    // Count and event register: clear > load > enable > hold
    always_ff @(posedge clock) begin
        if (clear) begin
            r_count   <= c_reset;
            r_wrapped <= 1'b0;
        end else if (load) begin
            r_count   <= w_load_clamped;
            r_wrapped <= 1'b0;
        end else if (en) begin
            r_count   <= w_step;
            r_wrapped <= w_tc;
        end else begin
            r_wrapped <= 1'b0;
        end
    end

    assign count   = r_count;
    assign tc      = w_tc;
    assign wrapped = r_wrapped;

endmodule : sync_updown_counter
`default_nettype wire
